// File: rtl/mul_result_tx.sv
// mul_result_tx: byte-serial 4-phase req/ack transmitter for one 64-bit multiplier product, LSB byte first.
// Latency: byte0 and tx_req appear one clk after accept; each ack edge reaches the FSM after 2 sync flops (min 6 clk/byte).
// Backpressure: res_ready is high only in IDLE; the host paces every byte through tx_ack. Optional macro TX_CHECKSUM_EN appends an XOR byte.
module mul_result_tx #(
   parameter  int RES_W  = 64,
   localparam int NBYTES = RES_W / 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             res_valid,
   input  logic [RES_W-1:0] res_data,
   output logic             res_ready,
   output logic [7:0]       tx_data,
   output logic             tx_req,
   input  logic             tx_ack,
   output logic             tx_last,
   output logic             busy
);

`ifdef TX_CHECKSUM_EN
   localparam int NFRAME = NBYTES + 1;
`else
   localparam int NFRAME = NBYTES;
`endif
   localparam int SH_W  = NFRAME * 8;
   localparam int IDX_W = (NFRAME > 1) ? $clog2(NFRAME) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NFRAME - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_ACKLO = 2'd2
   } state_t;

   state_t             r_state;
   logic               r_ack_meta;
   logic               r_ack_s;
   logic [SH_W-1:0]    r_shift;
   logic [IDX_W-1:0]   r_idx;

   logic [SH_W-1:0]    w_load;
   logic [SH_W-1:0]    w_shift_nxt;
   logic [IDX_W-1:0]   w_idx_nxt;

`ifdef TX_CHECKSUM_EN
   logic [7:0]         w_csum;

   // XOR of all product bytes, parked in the top byte of the shift register so it goes out last
   always_comb begin
      w_csum = 8'h00;
      for (int k = 0; k < NBYTES; k++) begin
         w_csum = w_csum ^ res_data[8*k +: 8];
      end
      w_load = {w_csum, res_data};
   end
`else
   // Frame is just the product bytes
   always_comb begin
      w_load = res_data;
   end
`endif

   assign w_shift_nxt = r_shift >> 8;
   assign w_idx_nxt   = r_idx + 1'b1;

   // Two-flop synchronizer for the asynchronous host acknowledge
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ack_meta <= 1'b0;
         r_ack_s    <= 1'b0;
      end else begin
         r_ack_meta <= tx_ack;
         r_ack_s    <= r_ack_meta;
      end
   end

   // Handshake FSM with all outputs registered; tx_data only moves when entering REQ
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_shift   <= '0;
         r_idx     <= '0;
         res_ready <= 1'b1;
         tx_data   <= 8'h00;
         tx_req    <= 1'b0;
         tx_last   <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (res_valid) begin
                  r_shift   <= w_load;
                  r_idx     <= '0;
                  tx_data   <= w_load[7:0];
                  tx_req    <= 1'b1;
                  tx_last   <= (LAST_IDX == '0);
                  busy      <= 1'b1;
                  res_ready <= 1'b0;
                  r_state   <= ST_REQ;
               end
            end
            ST_REQ: begin
               // A host that never dropped ack still advances; phase ordering is the host's job
               if (r_ack_s) begin
                  tx_req  <= 1'b0;
                  r_state <= ST_ACKLO;
               end
            end
            ST_ACKLO: begin
               if (!r_ack_s) begin
                  if (r_idx == LAST_IDX) begin
                     tx_last   <= 1'b0;
                     busy      <= 1'b0;
                     res_ready <= 1'b1;
                     r_state   <= ST_IDLE;
                  end else begin
                     r_idx   <= w_idx_nxt;
                     r_shift <= w_shift_nxt;
                     tx_data <= w_shift_nxt[7:0];
                     tx_req  <= 1'b1;
                     tx_last <= (w_idx_nxt == LAST_IDX);
                     r_state <= ST_REQ;
                  end
               end
            end
            default: begin
               tx_req    <= 1'b0;
               tx_last   <= 1'b0;
               busy      <= 1'b0;
               res_ready <= 1'b1;
               r_state   <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mul_result_tx.sv
// Directed bench for mul_result_tx: host-side 4-phase responder with hand-chosen products.
// Inputs change and outputs are sampled 1 ns after each rising edge.
// Every byte, tx_last flag, handshake latency and data-stability window is compared against expected values.
module tb_mul_result_tx;

`ifdef TX_CHECKSUM_EN
   localparam int NF = 9;
`else
   localparam int NF = 8;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        res_valid;
   logic [63:0] res_data;
   logic        res_ready;
   logic [7:0]  tx_data;
   logic        tx_req;
   logic        tx_ack;
   logic        tx_last;
   logic        busy;

   int n_chk = 0;
   int n_err = 0;

   mul_result_tx dut (
      .clk       (clk),
      .rst       (rst),
      .res_valid (res_valid),
      .res_data  (res_data),
      .res_ready (res_ready),
      .tx_data   (tx_data),
      .tx_req    (tx_req),
      .tx_ack    (tx_ack),
      .tx_last   (tx_last),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_rdy"},  res_ready, 1'b1);
      check({tag, "_req"},  tx_req,    1'b0);
      check({tag, "_dat"},  tx_data,   8'h00);
      check({tag, "_last"}, tx_last,   1'b0);
      check({tag, "_busy"}, busy,      1'b0);
   endtask

   // Present one product for a single accept cycle and check the first-byte timing
   task automatic accept(input logic [63:0] p);
      logic [7:0] b0;
      b0 = p[7:0];
      res_data  = p;
      res_valid = 1'b1;
      tick();
      check("acc_req",  tx_req,    1'b1);
      check("acc_b0",   tx_data,   b0);
      check("acc_busy", busy,      1'b1);
      check("acc_rdy",  res_ready, 1'b0);
      res_valid = 1'b0;
   endtask

   // Host side of one frame; dly = clk between seeing a request edge and answering it
   task automatic host(input logic [63:0] prod, input int dly, input int abort_at, input bit poke);
      logic [7:0] exp_b;
      logic [7:0] cs;
      logic [7:0] held;
      int         n;
      bit         ok;
      cs = 8'h00;
      for (int k = 0; k < 8; k++) cs = cs ^ prod[8*k +: 8];
      for (int b = 0; b < NF; b++) begin
         exp_b = (b < 8) ? prod[8*b +: 8] : cs;
         n = 0;
         while (tx_req !== 1'b1 && n < 300) begin tick(); n++; end
         if (tx_req !== 1'b1) begin check("req_tmo", 0, 1); return; end
         if (b == abort_at) return;
         check($sformatf("byte%0d", b), tx_data, exp_b);
         check($sformatf("last%0d", b), tx_last, (b == NF - 1));
         held = tx_data;
         ok   = 1'b1;
         for (int i = 0; i < dly; i++) begin
            if (poke && b == 2 && i == 0) begin
               res_valid = 1'b1;
               res_data  = '1;
            end
            tick();
            if (tx_data !== held || tx_req !== 1'b1) ok = 1'b0;
         end
         if (poke && b == 2) check("poke_rdy", res_ready, 1'b0);
         if (poke && b == 4) res_valid = 1'b0;
         tx_ack = 1'b1;
         n = 0;
         while (tx_req !== 1'b0 && n < 300) begin
            tick(); n++;
            if (tx_data !== held) ok = 1'b0;
         end
         check("ack_hi_lat", n, 3);
         for (int i = 0; i < dly; i++) begin
            tick();
            if (tx_data !== held || tx_req !== 1'b0) ok = 1'b0;
         end
         tx_ack = 1'b0;
         n = 0;
         if (b == NF - 1) begin
            while (res_ready !== 1'b1 && n < 300) begin
               if (tx_data !== held) ok = 1'b0;
               tick(); n++;
            end
            check("end_lat",  n,    3);
            check("end_busy", busy, 1'b0);
         end else begin
            while (tx_req !== 1'b1 && n < 300) begin
               if (tx_data !== held) ok = 1'b0;
               tick(); n++;
            end
            check("ack_lo_lat", n, 3);
         end
         check($sformatf("stable%0d", b), ok, 1'b1);
      end
   endtask

   initial begin
      rst       = 1'b1;
      res_valid = 1'b0;
      res_data  = '0;
      tx_ack    = 1'b0;
      repeat (3) tick();
      check_idle("rst");
      rst = 1'b0;
      repeat (5) tick();
      check_idle("idle");

      // Fast host: EF CD AB 89 67 45 23 01, tx_last only on 01
      accept(64'h0123_4567_89AB_CDEF);
      host(64'h0123_4567_89AB_CDEF, 1, -1, 1'b0);
      check("fast_rdy", res_ready, 1'b1);

      // Slow host with an all-ones product offered mid-frame
      accept(64'hA5A5_5A5A_0F0F_F0F0);
      host(64'hA5A5_5A5A_0F0F_F0F0, 20, -1, 1'b1);
      tick();
      check("poke_noacc_req",  tx_req, 1'b0);
      check("poke_noacc_busy", busy,   1'b0);

      // Reset while byte 3 is being requested, then a fresh product
      accept(64'h1122_3344_5566_7788);
      host(64'h1122_3344_5566_7788, 2, 3, 1'b0);
      rst = 1'b1;
      tick();
      check_idle("midrst");
      rst = 1'b0;
      tick();
      accept(64'h2);
      host(64'h2, 0, -1, 1'b0);

      // Checksum vector: 03 01 00.. then 02 when the checksum byte is enabled
      accept(64'h0000_0000_0000_0103);
      host(64'h0000_0000_0000_0103, 1, -1, 1'b0);

      // Back-to-back products held on res_valid
      accept(64'hDEAD_BEEF_CAFE_F00D);
      res_data  = 64'h0807_0605_0403_0201;
      res_valid = 1'b1;
      host(64'hDEAD_BEEF_CAFE_F00D, 1, -1, 1'b0);
      tick();
      check("b2b_req", tx_req,    1'b1);
      check("b2b_b0",  tx_data,   8'h01);
      check("b2b_rdy", res_ready, 1'b0);
      res_valid = 1'b0;
      host(64'h0807_0605_0403_0201, 1, -1, 1'b0);
      repeat (3) tick();
      check("final_busy", busy,      1'b0);
      check("final_rdy",  res_ready, 1'b1);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
